// File: rtl/regfile_write_queue_if.sv
// regfile_write_queue_if
//   Bundles the write-request, retire-enable, read-port and status signals of the
//   register-file write queue.
//   master : producer side (execute/memory stages, read-port users)
//     Wr_valid, Wr_addr, Wr_data   write request
//     Wr_ready                     queue can accept a request
//     Wb_en                        array write slot granted (retire enable)
//     Rd_addr1/2 -> Rd_data1/2     combinational read ports with forwarding
//     Count, Empty                 pending-entry status
//   slave  : the queue itself (directions reversed)
interface regfile_write_queue_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic              Wr_valid;
   logic              Wr_ready;
   logic [ADDR_W-1:0] Wr_addr;
   logic [DATA_W-1:0] Wr_data;
   logic              Wb_en;
   logic [ADDR_W-1:0] Rd_addr1;
   logic [DATA_W-1:0] Rd_data1;
   logic [ADDR_W-1:0] Rd_addr2;
   logic [DATA_W-1:0] Rd_data2;
   logic [CNT_W-1:0]  Count;
   logic              Empty;

   modport master (
      output Wr_valid, Wr_addr, Wr_data, Wb_en, Rd_addr1, Rd_addr2,
      input  Wr_ready, Rd_data1, Rd_data2, Count, Empty
   );

   modport slave (
      input  Wr_valid, Wr_addr, Wr_data, Wb_en, Rd_addr1, Rd_addr2,
      output Wr_ready, Rd_data1, Rd_data2, Count, Empty
   );
endinterface

// File: rtl/regfile_write_queue.sv
// regfile_write_queue
//   Write side of the 32x32 register file. Write-back requests are buffered in a
//   small FIFO and retired into the storage array one per cycle when Wb_en grants
//   the array write slot. Two combinational read ports see pending writes through
//   forwarding (newest matching entry wins). Register 0 is never written and
//   always reads as 0.
//   Ports:
//     Clk  rising-edge clock
//     Rst  asynchronous active-low reset (clears queue and array)
//     bus  regfile_write_queue_if.slave: write request, retire enable, read ports,
//          Count/Empty status
module regfile_write_queue #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 4
) (
   input logic                  Clk,
   input logic                  Rst,
   regfile_write_queue_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned NREG  = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q      [NREG];
   logic [ADDR_W-1:0] ent_addr_q [DEPTH];
   logic [DATA_W-1:0] ent_data_q [DEPTH];
   logic [PTR_W-1:0]  head_q;
   logic [PTR_W-1:0]  tail_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;
   logic              wr_ready;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] rd_addr    [2];
   logic [DATA_W-1:0] rd_data    [2];

   // Ready depends only on registered occupancy: no path from Wb_en.
   assign wr_ready = (count_q < CNT_W'(DEPTH));
   assign push     = bus.Wr_valid && wr_ready;
   assign pop      = bus.Wb_en && (count_q != '0);

   assign bus.Wr_ready = wr_ready;
   assign bus.Count    = count_q;
   assign bus.Empty    = (count_q == '0);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pending-write FIFO; full/empty is tracked by count_q, pointers just wrap.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_addr_q[i] <= '0;
            ent_data_q[i] <= '0;
         end
      end else begin
         if (push) begin
            ent_addr_q[tail_q] <= bus.Wr_addr;
            ent_data_q[tail_q] <= bus.Wr_data;
            tail_q             <= tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_q <= head_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

   // Storage array; a retiring entry aimed at r0 is simply dropped.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
      end else if (pop && (ent_addr_q[head_q] != '0)) begin
         mem_q[ent_addr_q[head_q]] <= ent_data_q[head_q];
      end
   end

   assign rd_addr[0] = bus.Rd_addr1;
   assign rd_addr[1] = bus.Rd_addr2;

   // Walk valid entries oldest to newest so the last match (newest) wins.
   always_comb begin
      for (int unsigned p = 0; p < 2; p++) begin
         rd_data[p] = mem_q[rd_addr[p]];
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (ent_addr_q[head_q + PTR_W'(i)] == rd_addr[p])) begin
               rd_data[p] = ent_data_q[head_q + PTR_W'(i)];
            end
         end
         if (rd_addr[p] == '0) begin
            rd_data[p] = '0;
         end
      end
   end

   assign bus.Rd_data1 = rd_data[0];
   assign bus.Rd_data2 = rd_data[1];
endmodule

// File: tb/tb_regfile_write_queue.sv
module tb_regfile_write_queue;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DEPTH  = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } ent_t;

   logic Clk = 1'b0;
   logic Rst;

   regfile_write_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) rf ();

   regfile_write_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (rf)
   );

   always #5 Clk = ~Clk;

   // Reference: scoreboard of accepted-but-not-retired writes plus architectural array.
   ent_t              sb[$];
   logic [DATA_W-1:0] marr [2**ADDR_W];
   int                n_chk  = 0;
   int                n_fail = 0;

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                      input logic [DATA_W-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      if (a == '0) return '0;
      v = marr[a];
      foreach (sb[i]) if (sb[i].a == a) v = sb[i].d;
      return v;
   endfunction

   task automatic model_clear();
      sb.delete();
      for (int i = 0; i < 2**ADDR_W; i++) marr[i] = '0;
   endtask

   // One clock with inputs as currently driven; retired entries are popped and
   // compared against the read port.
   task automatic step();
      bit   do_push;
      bit   do_pop;
      ent_t e;
      ent_t h;
      do_push = rf.Wr_valid && (sb.size() < DEPTH);
      do_pop  = rf.Wb_en && (sb.size() != 0);
      e       = {rf.Wr_addr, rf.Wr_data};
      @(posedge Clk);
      if (do_pop) begin
         h = sb.pop_front();
         if (h.a != '0) marr[h.a] = h.d;
      end
      if (do_push) sb.push_back(e);
      #1;
      if (do_pop) begin
         rf.Rd_addr2 = h.a;
         #1;
         chk("retire_read", rf.Rd_data2, exp_read(h.a));
      end
   endtask

   task automatic push1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      rf.Wr_valid = 1'b1;
      rf.Wr_addr  = a;
      rf.Wr_data  = d;
      step();
      rf.Wr_valid = 1'b0;
   endtask

   task automatic read1(input string tag, input logic [ADDR_W-1:0] a);
      rf.Rd_addr1 = a;
      #1;
      chk(tag, rf.Rd_data1, exp_read(a));
   endtask

   task automatic chk_status(input string tag);
      chk({tag, "_count"}, DATA_W'(rf.Count), DATA_W'(sb.size()));
      chk({tag, "_empty"}, DATA_W'(rf.Empty), DATA_W'(sb.size() == 0));
      chk({tag, "_ready"}, DATA_W'(rf.Wr_ready), DATA_W'(sb.size() < DEPTH));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst         = 1'b0;
      rf.Wr_valid = 1'b0;
      rf.Wr_addr  = '0;
      rf.Wr_data  = '0;
      rf.Wb_en    = 1'b0;
      rf.Rd_addr1 = '0;
      rf.Rd_addr2 = '0;
      model_clear();
      repeat (2) @(posedge Clk);
      #3 Rst = 1'b1;
      @(posedge Clk);
      #1;

      // Reset state
      rf.Rd_addr1 = 5;
      rf.Rd_addr2 = 31;
      #1;
      chk("rst_rd1", rf.Rd_data1, 32'h0);
      chk("rst_rd2", rf.Rd_data2, 32'h0);
      chk("rst_count", DATA_W'(rf.Count), 32'd0);
      chk("rst_empty", DATA_W'(rf.Empty), 32'd1);
      chk("rst_ready", DATA_W'(rf.Wr_ready), 32'd1);

      // Forward then retire
      push1(3, 32'hDEADBEEF);
      rf.Rd_addr1 = 3;
      #1;
      chk("fwd_rd1", rf.Rd_data1, 32'hDEADBEEF);
      chk("fwd_count", DATA_W'(rf.Count), 32'd1);
      rf.Wb_en = 1'b1;
      step();
      rf.Wb_en = 1'b0;
      chk("ret_count", DATA_W'(rf.Count), 32'd0);
      read1("ret_rd1", 3);
      chk("ret_rd1_const", rf.Rd_data1, 32'hDEADBEEF);

      // R0 protection
      push1(0, 32'hFFFFFFFF);
      read1("r0_pending", 0);
      chk("r0_pending_const", rf.Rd_data1, 32'h0);
      rf.Wb_en = 1'b1;
      step();
      rf.Wb_en = 1'b0;
      read1("r0_retired", 0);
      chk_status("r0");

      // Fill, backpressure, drain
      for (int k = 1; k <= 4; k++) push1(ADDR_W'(k), DATA_W'(k * 32'h11));
      chk_status("full");
      chk("full_ready_const", DATA_W'(rf.Wr_ready), 32'd0);
      push1(5, 32'h55);
      chk_status("full_reject");
      read1("full_reject_r5", 5);
      rf.Wb_en = 1'b1;
      repeat (4) step();
      rf.Wb_en = 1'b0;
      for (int k = 1; k <= 4; k++) read1("drain_rd", ADDR_W'(k));
      chk("drain_r4_const", rf.Rd_data1, 32'h44);
      chk_status("drain");

      // X on request fields while not valid
      rf.Wr_addr = 'x;
      rf.Wr_data = 'x;
      step();
      chk_status("x_idle");
      read1("x_idle_r1", 1);

      // Same-address ordering, then concurrent push/pop with pointer wrap
      push1(7, 32'hA);
      push1(7, 32'hB);
      push1(7, 32'hC);
      read1("same_r7", 7);
      chk("same_r7_const", rf.Rd_data1, 32'hC);
      rf.Wb_en = 1'b1;
      repeat (2) step();
      chk_status("pre_stream");
      rf.Wr_valid = 1'b1;
      rf.Wr_addr  = 7;
      for (int k = 0; k < 10; k++) begin
         rf.Wr_data = DATA_W'(32'h100 + k);
         step();
         chk("stream_count", DATA_W'(rf.Count), 32'd1);
         read1("stream_r7", 7);
      end
      rf.Wr_valid = 1'b0;
      step();
      rf.Wb_en = 1'b0;
      read1("stream_final_r7", 7);
      chk("stream_final_const", rf.Rd_data1, 32'h109);
      chk_status("stream_final");

      // Asynchronous reset with pending entries
      for (int k = 0; k < 3; k++) push1(2, 32'h55);
      chk_status("pre_rst");
      read1("pre_rst_r2", 2);
      #2 Rst = 1'b0;
      #1;
      model_clear();
      chk_status("mid_rst");
      rf.Rd_addr1 = 2;
      #1;
      chk("mid_rst_r2", rf.Rd_data1, 32'h0);
      @(posedge Clk);
      #3 Rst = 1'b1;
      rf.Wb_en = 1'b1;
      repeat (3) step();
      rf.Wb_en = 1'b0;
      read1("post_rst_r2", 2);
      read1("post_rst_r7", 7);
      chk_status("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
